// File: rtl/sramgen_sram_bist_model_if.sv
// Functional access port and BIST control/status bundle for the sramgen SRAM model.
// The master drives requests; the memory model is the slave.
interface sramgen_sram_bist_model_if #(
   parameter int DATA_WIDTH  = 8,
   parameter int ADDR_WIDTH  = 6,
   parameter int WMASK_WIDTH = 2
);
   logic                   ce;
   logic                   we;
   logic [WMASK_WIDTH-1:0] wmask;
   logic [ADDR_WIDTH-1:0]  addr;
   logic [DATA_WIDTH-1:0]  din;
   logic [DATA_WIDTH-1:0]  dout;
   logic                   dout_valid;
   logic                   bist_start;
   logic                   bist_inject;
   logic                   bist_busy;
   logic                   bist_done;
   logic                   bist_fail;
   logic [ADDR_WIDTH-1:0]  bist_fail_addr;

   modport master (
      output ce, we, wmask, addr, din, bist_start, bist_inject,
      input  dout, dout_valid, bist_busy, bist_done, bist_fail, bist_fail_addr
   );

   modport slave (
      input  ce, we, wmask, addr, din, bist_start, bist_inject,
      output dout, dout_valid, bist_busy, bist_done, bist_fail, bist_fail_addr
   );
endinterface

// File: rtl/sramgen_sram_bist_model.sv
// Parametrised single-port SRAM behavioural model with lane write mask, 1- or 2-cycle
// registered read and a March C- self-test engine that owns the array while busy.
module sramgen_sram_bist_model #(
   parameter int DATA_WIDTH   = 8,
   parameter int ADDR_WIDTH   = 6,
   parameter int WMASK_WIDTH  = 2,
   parameter int READ_LATENCY = 1,
   parameter int INJECT_ADDR  = 5
) (
   input  logic clk,
   input  logic rstb,
   sramgen_sram_bist_model_if.slave bus
);
   localparam int DEPTH  = 1 << ADDR_WIDTH;
   localparam int LANE_W = DATA_WIDTH / WMASK_WIDTH;
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
   localparam logic [ADDR_WIDTH-1:0] INJ_ADDR  = ADDR_WIDTH'(INJECT_ADDR);
   localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_W0_UP,
      ST_R0W1_UP,
      ST_R1W0_UP,
      ST_R0W1_DN,
      ST_R1W0_DN,
      ST_R0_UP,
      ST_DONE
   } bist_state_e;

   // NOTE: the array has no reset; contents survive rstb and only start at zero in simulation.
   logic [DATA_WIDTH-1:0] mem_q [DEPTH] = '{default: '0};

   bist_state_e           state_q;
   logic [ADDR_WIDTH-1:0] cnt_q;
   logic                  busy_q;
   logic                  done_q;
   logic                  fail_q;
   logic [ADDR_WIDTH-1:0] fail_addr_q;
   logic                  inject_q;

   logic                  pipe_valid_q, pipe_valid_d;
   logic [DATA_WIDTH-1:0] pipe_data_q,  pipe_data_d;
   logic                  dout_valid_q, dout_valid_d;
   logic [DATA_WIDTH-1:0] dout_q,       dout_d;

   logic                  func_wr;
   logic                  func_rd;
   logic                  bist_cmp;
   logic                  bist_wr;
   logic [DATA_WIDTH-1:0] bist_expect;
   logic [DATA_WIDTH-1:0] bist_wdata;
   logic                  bist_mismatch;
   logic                  mem_we;
   logic [ADDR_WIDTH-1:0] mem_waddr;
   logic [DATA_WIDTH-1:0] mem_wdata;
   logic [DATA_WIDTH-1:0] mem_wbits;
   logic                  stage_valid;
   logic [DATA_WIDTH-1:0] stage_data;

   assign func_wr = bus.ce && bus.we && !busy_q;
   assign func_rd = bus.ce && !bus.we && !busy_q;

   // March element decode: what to expect at cnt_q and what to leave behind.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      bist_cmp    = 1'b0;
      bist_wr     = 1'b0;
      bist_expect = '0;
      bist_wdata  = '0;
      unique case (state_q)
         ST_W0_UP: begin
            bist_wr = 1'b1;
            if (inject_q && (cnt_q == INJ_ADDR)) bist_wdata[0] = 1'b1;
         end
         ST_R0W1_UP, ST_R0W1_DN: begin
            bist_cmp   = 1'b1;
            bist_wr    = 1'b1;
            bist_wdata = '1;
         end
         ST_R1W0_UP, ST_R1W0_DN: begin
            bist_cmp    = 1'b1;
            bist_wr     = 1'b1;
            bist_expect = '1;
         end
         ST_R0_UP: bist_cmp = 1'b1;
         default: ;
      endcase
      bist_mismatch = bist_cmp && (mem_q[cnt_q] != bist_expect);
   end

   // Single write port: the engine owns it while busy, otherwise lane-masked functional writes.
   always_comb begin
      mem_we    = 1'b0;
      mem_waddr = bus.addr;
      mem_wdata = bus.din;
      mem_wbits = '0;
      if (busy_q) begin
         mem_we    = bist_wr;
         mem_waddr = cnt_q;
         mem_wdata = bist_wdata;
         mem_wbits = '1;
      end else if (func_wr) begin
         mem_we = 1'b1;
         for (int k = 0; k < WMASK_WIDTH; k++) begin
            mem_wbits[k*LANE_W +: LANE_W] = {LANE_W{bus.wmask[k]}};
         end
      end
   end

   always_ff @(posedge clk) begin
      if (mem_we) mem_q[mem_waddr] <= (mem_q[mem_waddr] & ~mem_wbits) | (mem_wdata & mem_wbits);
   end

   // Read pipeline: stage one captures the array, the output register then sees latency 1 or 2.
   always_comb begin
      pipe_valid_d = func_rd;
      pipe_data_d  = mem_q[bus.addr];
      if (READ_LATENCY == 2) begin
         stage_valid = pipe_valid_q;
         stage_data  = pipe_data_q;
      end else begin
         stage_valid = pipe_valid_d;
         stage_data  = pipe_data_d;
      end
      dout_valid_d = stage_valid;
      dout_d       = stage_valid ? stage_data : dout_q;
   end

   always_ff @(posedge clk) begin
      // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
      if (!rstb) begin
         pipe_valid_q <= 1'b0;
         pipe_data_q  <= '0;
         dout_valid_q <= 1'b0;
         dout_q       <= '0;
      end else begin
         pipe_valid_q <= pipe_valid_d;
         pipe_data_q  <= pipe_data_d;
         dout_valid_q <= dout_valid_d;
         dout_q       <= dout_d;
      end
   end

   always_ff @(posedge clk) begin
      if (!rstb) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         fail_q      <= 1'b0;
         fail_addr_q <= '0;
         inject_q    <= 1'b0;
      end else begin
         if (bist_mismatch && !fail_q) begin
            fail_q      <= 1'b1;
            fail_addr_q <= cnt_q;
         end
         unique case (state_q)
            ST_IDLE: begin
               if (bus.bist_start) begin
                  state_q     <= ST_W0_UP;
                  cnt_q       <= '0;
                  busy_q      <= 1'b1;
                  done_q      <= 1'b0;
                  fail_q      <= 1'b0;
                  fail_addr_q <= '0;
                  inject_q    <= bus.bist_inject;
               end
            end
            ST_W0_UP: begin
               cnt_q <= cnt_q + ADDR_ONE;
               if (cnt_q == LAST_ADDR) state_q <= ST_R0W1_UP;
            end
            ST_R0W1_UP: begin
               cnt_q <= cnt_q + ADDR_ONE;
               if (cnt_q == LAST_ADDR) state_q <= ST_R1W0_UP;
            end
            ST_R1W0_UP: begin
               cnt_q <= cnt_q + ADDR_ONE;
               if (cnt_q == LAST_ADDR) begin
                  state_q <= ST_R0W1_DN;
                  cnt_q   <= LAST_ADDR;
               end
            end
            ST_R0W1_DN: begin
               cnt_q <= cnt_q - ADDR_ONE;
               if (cnt_q == '0) state_q <= ST_R1W0_DN;
            end
            ST_R1W0_DN: begin
               cnt_q <= cnt_q - ADDR_ONE;
               if (cnt_q == '0) begin
                  state_q <= ST_R0_UP;
                  cnt_q   <= '0;
               end
            end
            ST_R0_UP: begin
               cnt_q <= cnt_q + ADDR_ONE;
               if (cnt_q == LAST_ADDR) state_q <= ST_DONE;
            end
            ST_DONE: begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b1;
            end
         endcase
      end
   end

   assign bus.dout           = dout_q;
   assign bus.dout_valid     = dout_valid_q;
   assign bus.bist_busy      = busy_q;
   assign bus.bist_done      = done_q;
   assign bus.bist_fail      = fail_q;
   assign bus.bist_fail_addr = fail_addr_q;
endmodule

// File: tb/tb_sramgen_sram_bist_model.sv
// Bench for the sramgen SRAM/BIST model: u_dut1 uses READ_LATENCY=1, u_dut2 READ_LATENCY=2.
// Read expectations are queued when a read is driven and retired when dout_valid appears.
module tb_sramgen_sram_bist_model;
   typedef struct {
      logic [7:0] data;
      int         due;
   } exp_t;

   logic clk;
   logic rstb;
   int   cyc;
   int   n_checks;
   int   n_fail;

   exp_t       sb1[$];
   exp_t       sb2[$];
   logic [7:0] model1 [64];
   logic [7:0] model2 [64];

   sramgen_sram_bist_model_if #(.DATA_WIDTH(8), .ADDR_WIDTH(6), .WMASK_WIDTH(2)) b1 ();
   sramgen_sram_bist_model_if #(.DATA_WIDTH(8), .ADDR_WIDTH(6), .WMASK_WIDTH(2)) b2 ();

   sramgen_sram_bist_model #(
      .DATA_WIDTH(8), .ADDR_WIDTH(6), .WMASK_WIDTH(2), .READ_LATENCY(1), .INJECT_ADDR(5)
   ) u_dut1 (.clk(clk), .rstb(rstb), .bus(b1));

   sramgen_sram_bist_model #(
      .DATA_WIDTH(8), .ADDR_WIDTH(6), .WMASK_WIDTH(2), .READ_LATENCY(2), .INJECT_ADDR(5)
   ) u_dut2 (.clk(clk), .rstb(rstb), .bus(b2));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Scoreboard for dut1: every dout_valid must match the oldest expectation on its due cycle.
   always @(negedge clk) begin : mon1
      exp_t e;
      if (rstb === 1'b1) begin
         if (b1.dout_valid === 1'b1) begin
            n_checks++;
            if (sb1.size() == 0) begin
               n_fail++;
               $display("FAIL dut1_unexpected_valid: got dout=%h at cycle %0d, required no dout_valid", b1.dout, cyc);
            end else begin
               e = sb1.pop_front();
               if (b1.dout !== e.data || cyc != e.due) begin
                  n_fail++;
                  $display("FAIL dut1_read: got dout=%h at cycle %0d, required %h at cycle %0d", b1.dout, cyc, e.data, e.due);
               end
            end
         end else if (sb1.size() != 0 && sb1[0].due < cyc) begin
            n_checks++;
            n_fail++;
            e = sb1.pop_front();
            $display("FAIL dut1_missing_valid: got no dout_valid by cycle %0d, required %h at cycle %0d", cyc, e.data, e.due);
         end
      end
   end

   always @(negedge clk) begin : mon2
      exp_t e;
      if (rstb === 1'b1) begin
         if (b2.dout_valid === 1'b1) begin
            n_checks++;
            if (sb2.size() == 0) begin
               n_fail++;
               $display("FAIL dut2_unexpected_valid: got dout=%h at cycle %0d, required no dout_valid", b2.dout, cyc);
            end else begin
               e = sb2.pop_front();
               if (b2.dout !== e.data || cyc != e.due) begin
                  n_fail++;
                  $display("FAIL dut2_read: got dout=%h at cycle %0d, required %h at cycle %0d", b2.dout, cyc, e.data, e.due);
               end
            end
         end else if (sb2.size() != 0 && sb2[0].due < cyc) begin
            n_checks++;
            n_fail++;
            e = sb2.pop_front();
            $display("FAIL dut2_missing_valid: got no dout_valid by cycle %0d, required %h at cycle %0d", cyc, e.data, e.due);
         end
      end
   end

   task automatic wr1(input logic [5:0] a, input logic [7:0] d, input logic [1:0] m);
      @(negedge clk);
      b1.ce = 1'b1; b1.we = 1'b1; b1.addr = a; b1.din = d; b1.wmask = m;
      for (int k = 0; k < 2; k++) if (m[k]) model1[a][k*4 +: 4] = d[k*4 +: 4];
   endtask

   task automatic rd1(input logic [5:0] a);
      exp_t e;
      @(negedge clk);
      b1.ce = 1'b1; b1.we = 1'b0; b1.addr = a; b1.wmask = 2'b00;
      e.data = model1[a];
      e.due  = cyc + 1;
      sb1.push_back(e);
   endtask

   task automatic wr2(input logic [5:0] a, input logic [7:0] d, input logic [1:0] m);
      @(negedge clk);
      b2.ce = 1'b1; b2.we = 1'b1; b2.addr = a; b2.din = d; b2.wmask = m;
      for (int k = 0; k < 2; k++) if (m[k]) model2[a][k*4 +: 4] = d[k*4 +: 4];
   endtask

   task automatic rd2(input logic [5:0] a);
      exp_t e;
      @(negedge clk);
      b2.ce = 1'b1; b2.we = 1'b0; b2.addr = a; b2.wmask = 2'b00;
      e.data = model2[a];
      e.due  = cyc + 2;
      sb2.push_back(e);
   endtask

   task automatic idle_all();
      @(negedge clk);
      b1.ce = 1'b0; b1.we = 1'b0; b1.bist_start = 1'b0; b1.bist_inject = 1'b0;
      b2.ce = 1'b0; b2.we = 1'b0; b2.bist_start = 1'b0; b2.bist_inject = 1'b0;
   endtask

   task automatic drain(input string tag);
      for (int i = 0; i < 6; i++) idle_all();
      n_checks++;
      if (sb1.size() != 0 || sb2.size() != 0) begin
         n_fail++;
         $display("FAIL %s_drain: got %0d/%0d reads outstanding, required 0/0", tag, sb1.size(), sb2.size());
      end
   endtask

   // Start a BIST run on dut1 and stay until bist_busy falls (bounded). Optionally issue a read
   // in the start cycle, or hammer the functional port and re-pulse bist_start while busy.
   task automatic run_bist1(input logic inj, input bit gate, input bit rd_in_flight,
                            input logic [5:0] ra, output int busy_cycles, output int gated_valids);
      exp_t e;
      @(negedge clk);
      b1.bist_start = 1'b1; b1.bist_inject = inj;
      if (rd_in_flight) begin
         b1.ce = 1'b1; b1.we = 1'b0; b1.addr = ra;
         e.data = model1[ra];
         e.due  = cyc + 1;
         sb1.push_back(e);
      end else begin
         b1.ce = 1'b0;
      end
      @(negedge clk);
      b1.bist_start = 1'b0; b1.bist_inject = 1'b0; b1.ce = 1'b0;
      busy_cycles  = 0;
      gated_valids = 0;
      n_checks++;
      if (b1.bist_busy !== 1'b1) begin
         n_fail++;
         $display("FAIL bist_busy_rise: got %b, required 1", b1.bist_busy);
      end
      n_checks++;
      if (b1.bist_done !== 1'b0 || b1.bist_fail !== 1'b0) begin
         n_fail++;
         $display("FAIL bist_start_clear: got done=%b fail=%b, required 0 0", b1.bist_done, b1.bist_fail);
      end
      while (b1.bist_busy === 1'b1 && busy_cycles < 1000) begin
         busy_cycles++;
         if (gate) begin
            if (b1.dout_valid === 1'b1) gated_valids++;
            b1.ce = 1'b1; b1.we = 1'b1; b1.wmask = 2'b11; b1.addr = 6'd7; b1.din = 8'hFF;
            b1.bist_start  = (busy_cycles == 50);
            b1.bist_inject = (busy_cycles == 50);
         end
         @(negedge clk);
      end
      b1.ce = 1'b0; b1.we = 1'b0; b1.bist_start = 1'b0; b1.bist_inject = 1'b0;
   endtask

   task automatic check_bist_end(input string tag, input int busy_cycles,
                                 input logic exp_fail, input logic [5:0] exp_addr);
      n_checks++;
      if (busy_cycles != 385) begin
         n_fail++;
         $display("FAIL %s_busy_len: got %0d cycles, required 385", tag, busy_cycles);
      end
      n_checks++;
      if (b1.bist_done !== 1'b1) begin
         n_fail++;
         $display("FAIL %s_done: got %b, required 1", tag, b1.bist_done);
      end
      n_checks++;
      if (b1.bist_fail !== exp_fail || b1.bist_fail_addr !== exp_addr) begin
         n_fail++;
         $display("FAIL %s_result: got fail=%b addr=%0d, required fail=%b addr=%0d",
                  tag, b1.bist_fail, b1.bist_fail_addr, exp_fail, exp_addr);
      end
   endtask

   task automatic test_reset();
      rstb = 1'b0;
      repeat (3) @(negedge clk);
      n_checks++;
      if (b1.dout !== 8'h00 || b1.dout_valid !== 1'b0 || b2.dout !== 8'h00 || b2.dout_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_dout: got %h/%b %h/%b, required 00/0 00/0", b1.dout, b1.dout_valid, b2.dout, b2.dout_valid);
      end
      n_checks++;
      if (b1.bist_busy !== 1'b0 || b1.bist_done !== 1'b0 || b1.bist_fail !== 1'b0 || b1.bist_fail_addr !== 6'd0) begin
         n_fail++;
         $display("FAIL reset_bist: got busy=%b done=%b fail=%b addr=%0d, required 0 0 0 0",
                  b1.bist_busy, b1.bist_done, b1.bist_fail, b1.bist_fail_addr);
      end
      rstb = 1'b1;
   endtask

   task automatic test_masked_write();
      wr1(6'd3, 8'hFF, 2'b11);
      wr1(6'd3, 8'h00, 2'b01);
      rd1(6'd3);
      n_checks++;
      if (model1[3] !== 8'hF0) begin
         n_fail++;
         $display("FAIL masked_model: got %h, required F0", model1[3]);
      end
      drain("masked");
   endtask

   task automatic test_back_to_back();
      logic [7:0] last;
      wr1(6'd10, 8'h3C, 2'b11);
      rd1(6'd10);
      wr1(6'd11, 8'h96, 2'b11);
      wr1(6'd11, 8'h5A, 2'b10);
      rd1(6'd11);
      rd1(6'd3);
      rd1(6'd63);
      rd1(6'd10);
      last = model1[10];
      drain("b2b");
      n_checks++;
      if (b1.dout !== last || b1.dout_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL b2b_hold: got dout=%h valid=%b, required %h 0", b1.dout, b1.dout_valid, last);
      end
   endtask

   task automatic test_latency();
      wr2(6'd63, 8'hA5, 2'b11);
      rd2(6'd63);
      rd2(6'd0);
      rd2(6'd63);
      drain("latency");
      n_checks++;
      if (b2.dout !== 8'hA5 || b2.dout_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL latency_hold: got dout=%h valid=%b, required A5 0", b2.dout, b2.dout_valid);
      end
   endtask

   task automatic test_clean_bist();
      int bc;
      int gv;
      for (int a = 0; a < 64; a++) wr1(6'(a), 8'($urandom_range(0, 255)), 2'b11);
      run_bist1(1'b0, 1'b0, 1'b1, 6'd17, bc, gv);
      check_bist_end("clean", bc, 1'b0, 6'd0);
      for (int a = 0; a < 64; a++) model1[a] = 8'h00;
      for (int a = 0; a < 64; a++) rd1(6'(a));
      drain("clean");
   endtask

   task automatic test_gating();
      int bc;
      int gv;
      run_bist1(1'b0, 1'b1, 1'b0, 6'd0, bc, gv);
      check_bist_end("gating", bc, 1'b0, 6'd0);
      n_checks++;
      if (gv != 0) begin
         n_fail++;
         $display("FAIL gating_valid: got %0d dout_valid cycles while busy, required 0", gv);
      end
      rd1(6'd7);
      rd1(6'd6);
      drain("gating");
   endtask

   task automatic test_inject();
      int bc;
      int gv;
      run_bist1(1'b1, 1'b0, 1'b0, 6'd0, bc, gv);
      check_bist_end("inject", bc, 1'b1, 6'd5);
      rd1(6'd5);
      rd1(6'd4);
      drain("inject");
   endtask

   task automatic test_reset_mid_bist();
      int bc;
      int gv;
      @(negedge clk);
      b1.bist_start = 1'b1; b1.bist_inject = 1'b1;
      @(negedge clk);
      b1.bist_start = 1'b0; b1.bist_inject = 1'b0;
      for (int i = 1; i < 100; i++) @(negedge clk);
      n_checks++;
      if (b1.bist_busy !== 1'b1 || b1.bist_fail !== 1'b1) begin
         n_fail++;
         $display("FAIL midrun_state: got busy=%b fail=%b at cycle 100, required 1 1", b1.bist_busy, b1.bist_fail);
      end
      rstb = 1'b0;
      @(negedge clk);
      n_checks++;
      if (b1.bist_busy !== 1'b0 || b1.bist_done !== 1'b0 || b1.bist_fail !== 1'b0 ||
          b1.dout_valid !== 1'b0 || b1.bist_fail_addr !== 6'd0) begin
         n_fail++;
         $display("FAIL midrun_reset: got busy=%b done=%b fail=%b valid=%b addr=%0d, required 0 0 0 0 0",
                  b1.bist_busy, b1.bist_done, b1.bist_fail, b1.dout_valid, b1.bist_fail_addr);
      end
      rstb = 1'b1;
      run_bist1(1'b0, 1'b0, 1'b0, 6'd0, bc, gv);
      check_bist_end("rerun", bc, 1'b0, 6'd0);
      rd1(6'd0);
      rd1(6'd5);
      rd1(6'd63);
      drain("rerun");
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      rstb     = 1'b0;
      for (int a = 0; a < 64; a++) begin
         model1[a] = 8'h00;
         model2[a] = 8'h00;
      end
      b1.ce = 1'b0; b1.we = 1'b0; b1.wmask = 2'b00; b1.addr = '0; b1.din = '0;
      b1.bist_start = 1'b0; b1.bist_inject = 1'b0;
      b2.ce = 1'b0; b2.we = 1'b0; b2.wmask = 2'b00; b2.addr = '0; b2.din = '0;
      b2.bist_start = 1'b0; b2.bist_inject = 1'b0;

      test_reset();
      test_masked_write();
      test_back_to_back();
      test_latency();
      test_clean_bist();
      test_gating();
      test_inject();
      test_reset_mid_bist();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/sramgen_sram_bist_model.md
# sramgen_sram_bist_model

Parametrised single-port SRAM behavioural model, the next generation of the fixed 64x4 model. Adds configurable width, depth and mask granularity, a chip enable, a configurable read latency with a valid strobe, and a built-in March C- self-test engine. It sits at the macro boundary in RTL simulation and stands in for sramgen-generated macros during SoC bring-up and BIST flow checks.

## Interface
- DATA_WIDTH, 8, data word width in bits; must be a multiple of WMASK_WIDTH.
- ADDR_WIDTH, 6, address width; depth D = 2**ADDR_WIDTH.
- WMASK_WIDTH, 2, write-mask lanes; lane k covers bits [k*L +: L], where L = DATA_WIDTH/WMASK_WIDTH.
- READ_LATENCY, 1, number of cycles from read request to data; legal values are 1 and 2.
- INJECT_ADDR, 5, address whose bit 0 is corrupted when fault injection is armed.
- clk  input  1  clock; all logic is on the rising edge.
- rstb  input  1  synchronous reset, active-low.
- ce  input  1  functional access enable.
- we  input  1  write enable; 0 means read.
- wmask  input  WMASK_WIDTH  per-lane write enable.
- addr  input  ADDR_WIDTH  functional address.
- din  input  DATA_WIDTH  write data.
- dout  output  DATA_WIDTH  read data, registered.
- dout_valid  output  1  one-cycle strobe that qualifies dout.
- bist_start  input  1  single-cycle request to start BIST.
- bist_inject  input  1  sampled together with bist_start; arms fault injection.
- bist_busy  output  1  high while BIST is running.
- bist_done  output  1  sticky; set when BIST completes.
- bist_fail  output  1  sticky; set on the first compare mismatch.
- bist_fail_addr  output  ADDR_WIDTH  address of the first mismatch.

## Operation
- Memory array: D words. For simulation only, all words initialise to 0. Reset does not clear the array.
- Functional write (ce=1, we=1, bist_busy=0): each lane k with wmask[k]=1 takes din for that lane. Lanes with wmask[k]=0 keep their old value. dout holds its value; no X is driven.
- Functional read (ce=1, we=0, bist_busy=0): mem[addr] is captured into the read pipeline.
- With ce=0, or while bist_busy=1, functional inputs are ignored. No write occurs and no dout_valid is produced.
- BIST start: on bist_start=1 with bist_busy=0, the engine clears bist_done, bist_fail and bist_fail_addr, latches bist_inject, and enters W0_UP on the next cycle.
  - bist_start is ignored while bist_busy=1.
- BIST state machine: IDLE -> W0_UP -> R0W1_UP -> R1W0_UP -> R0W1_DN -> R1W0_DN -> R0_UP -> DONE -> IDLE.
  - Each march element visits one address per cycle. UP elements run 0..D-1; DN elements run D-1..0.
  - W0_UP: writes all-zeros. If injection is armed, it writes bit 0 = 1 at INJECT_ADDR.
  - RxWy elements: compare mem[a] against all-x, then write all-y to a, in the same cycle. The compare uses the array's combinational contents.
  - R0_UP: compare only.
  - First mismatch: set bist_fail=1 and record bist_fail_addr. Later mismatches do not update either output. The engine runs to completion regardless of mismatches.
  - DONE: lasts one cycle. It sets bist_done=1, which stays set until the next bist_start or reset.
- Address counter: ADDR_WIDTH bits. An element advances on the wrap of the counter, D-1 -> 0 for UP and 0 -> D-1 for DN.
- After a clean run, every word reads 0.

## Timing
- Reset (rstb=0 at a rising edge) drives:
  - dout=0, dout_valid=0;
  - the read pipeline cleared;
  - bist_busy=0, bist_done=0, bist_fail=0, bist_fail_addr=0;
  - FSM to IDLE.
- Reset mid-BIST aborts the run. Memory keeps whatever the partial run wrote.
- READ_LATENCY=1: a read request at edge N drives dout and dout_valid=1 after edge N+1.
- READ_LATENCY=2: dout and dout_valid=1 appear after edge N+2.
- Back-to-back reads give back-to-back valid data. dout holds its value when dout_valid=0.
- Read of an address written in the previous cycle returns the new data.
- bist_busy rises the cycle after the accepted bist_start. It stays high for 6*D cycles (384 at D=64) plus 1 DONE cycle.
- bist_done rises in the same cycle that bist_busy falls.
- Read-pipeline stages already in flight at bist_start still complete and strobe dout_valid.

## Test plan
- Masked write: with defaults, write 0xFF to address 3 with wmask=11, then write 0x00 with wmask=01, then read address 3. Required: dout=0xF0 with dout_valid one cycle after the read.
- Latency: with READ_LATENCY=2, write 0xA5 to address 63, then read it. Required: dout=0xA5 and dout_valid=1 exactly two cycles after the read. Back-to-back reads of addresses 0 and 63 give two consecutive valid cycles.
- Clean BIST: preload random data, then pulse bist_start. Required: bist_busy stays high 385 cycles, then bist_done=1 and bist_fail=0. Reads of addresses 0..63 all return 0.
- Injected fault: pulse bist_start with bist_inject=1. Required: bist_fail=1 and bist_fail_addr=5 after completion. bist_done=1 is still reached.
- Gating: during BIST, drive ce=1, we=1, addr=7, din=0xFF. Required: no effect on memory or on the BIST result, and no dout_valid. A second bist_start while busy is ignored.
- Reset mid-BIST: apply rstb=0 at cycle 100 of a run. Required: the next cycle shows bist_busy=0, bist_done=0, bist_fail=0 and dout_valid=0. A new run then completes clean.
